// File: rtl/vga_scanout.sv
// VGA scan-out engine: raster counters, delayed sync/blanking, pixel requests
// issued PIPELINE_STAGES ahead, and registered colour with underrun handling.
`timescale 1ns/1ps

module vga_scanout #(
    parameter int WIDTH              = 640,
    parameter int HEIGHT             = 480,
    parameter int HSYNC_FPORCH       = 16,
    parameter int HSYNC_PULSE        = 96,
    parameter int HSYNC_BPORCH       = 48,
    parameter int VSYNC_FPORCH       = 10,
    parameter int VSYNC_PULSE        = 2,
    parameter int VSYNC_BPORCH       = 33,
    parameter int HSYNC_POLARITY_NEG = 1,
    parameter int VSYNC_POLARITY_NEG = 1,
    parameter int PIPELINE_STAGES    = 2,
    parameter int COLOR_BITS         = 4,
    parameter logic [3*COLOR_BITS-1:0] UNDERRUN_RGB = {3*COLOR_BITS{1'b1}},
    parameter int FRAME_CNT_WID      = 16,
    localparam int H_SIZE = WIDTH + HSYNC_FPORCH + HSYNC_PULSE + HSYNC_BPORCH,
    localparam int V_SIZE = HEIGHT + VSYNC_FPORCH + VSYNC_PULSE + VSYNC_BPORCH,
    localparam int HW     = $clog2(H_SIZE),
    localparam int VW     = $clog2(V_SIZE),
    localparam int CW     = 3 * COLOR_BITS
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     enable,
    input  logic                     underrun_clr,
    output logic                     pixIf_NEXT_FRAME,
    output logic                     pixIf_H_BLANKING,
    output logic [HW-1:0]            pixIf_H_CNT,
    output logic [VW-1:0]            pixIf_next_V_CNT,
    input  logic [CW-1:0]            pixIf_rgb,
    input  logic                     pixIf_valid,
    output logic                     vgaIf_vga_h_sync,
    output logic                     vgaIf_vga_v_sync,
    output logic [CW-1:0]            vgaIf_vga_rgb,
    output logic [FRAME_CNT_WID-1:0] frame_cnt,
    output logic                     underrun
);

    localparam int PS     = PIPELINE_STAGES;
    localparam int HS_ON  = WIDTH + HSYNC_FPORCH;
    localparam int HS_OFF = HS_ON + HSYNC_PULSE;
    localparam int VS_ON  = HEIGHT + VSYNC_FPORCH;
    localparam int VS_OFF = VS_ON + VSYNC_PULSE;
    localparam logic HPOL = (HSYNC_POLARITY_NEG != 0);
    localparam logic VPOL = (VSYNC_POLARITY_NEG != 0);
    localparam logic [HW-1:0] H_LAST = HW'(H_SIZE - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_SIZE - 1);

    logic [HW-1:0]            h_cnt_q, h_cnt_d;
    logic [VW-1:0]            v_cnt_q, v_cnt_d;
    logic [PS:0]              hs_q, hs_d;
    logic [PS:0]              vs_q, vs_d;
    logic [CW-1:0]            rgb_q, rgb_d;
    logic                     enable_q, enable_d;
    logic [FRAME_CNT_WID-1:0] frame_cnt_q, frame_cnt_d;
    logic                     underrun_q, underrun_d;

    logic [31:0] h_w, v_w;
    logic        h_last, v_last, frame_start;
    logic        active, act_tap, under_set;

    assign h_w = 32'(h_cnt_q);
    assign v_w = 32'(v_cnt_q);

    always_comb begin
        h_last      = (h_cnt_q == H_LAST);
        v_last      = (v_cnt_q == V_LAST);
        frame_start = h_last && v_last;
        active      = (h_w < WIDTH) && (v_w < HEIGHT);

        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end

        // Sync levels are stored already polarity-corrected.
        hs_d[0] = ((h_w >= HS_ON) && (h_w < HS_OFF)) ^ HPOL;
        vs_d[0] = ((v_w >= VS_ON) && (v_w < VS_OFF)) ^ VPOL;
        for (int i = 1; i <= PS; i++) begin
            hs_d[i] = hs_q[i-1];
            vs_d[i] = vs_q[i-1];
        end
    end

    generate
        if (PS == 0) begin : g_act0
            assign act_tap = active;
        end else begin : g_actn
            logic [PS-1:0] act_q, act_d;
            always_comb begin
                act_d[0] = active;
                for (int i = 1; i < PS; i++) begin
                    act_d[i] = act_q[i-1];
                end
            end
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    act_q <= '0;
                end else begin
                    act_q <= act_d;
                end
            end
            assign act_tap = act_q[PS-1];
        end
    endgenerate

    always_comb begin
        rgb_d     = '0;
        under_set = 1'b0;
        if (act_tap && enable_q) begin
            if (pixIf_valid) begin
                rgb_d = pixIf_rgb;
            end else begin
                rgb_d     = UNDERRUN_RGB;
                under_set = 1'b1;
            end
        end
        underrun_d  = under_set | (underrun_q & ~underrun_clr);
        enable_d    = frame_start ? enable : enable_q;
        frame_cnt_d = frame_start ? frame_cnt_q + 1'b1 : frame_cnt_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            hs_q        <= {(PS+1){HPOL}};
            vs_q        <= {(PS+1){VPOL}};
            rgb_q       <= '0;
            enable_q    <= 1'b0;
            frame_cnt_q <= '0;
            underrun_q  <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            rgb_q       <= rgb_d;
            enable_q    <= enable_d;
            frame_cnt_q <= frame_cnt_d;
            underrun_q  <= underrun_d;
        end
    end

    assign pixIf_NEXT_FRAME = (v_w == HEIGHT - 1) && (h_w == WIDTH);
    assign pixIf_H_BLANKING = (h_w >= WIDTH);
    assign pixIf_H_CNT      = h_cnt_q;
    assign pixIf_next_V_CNT = v_last ? '0 : v_cnt_q + 1'b1;
    assign vgaIf_vga_h_sync = hs_q[PS];
    assign vgaIf_vga_v_sync = vs_q[PS];
    assign vgaIf_vga_rgb    = rgb_q;
    assign frame_cnt        = frame_cnt_q;
    assign underrun         = underrun_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: small raster (A) and default geometry (B).
`timescale 1ns/1ps

module tb_vga_scanout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst_b_n, enable, underrun_clr, valid;
    logic [3:0]  p1, p2;
    logic [11:0] rgb_a;
    logic [11:0] rgb_in_b;

    logic        nf_a, hb_a, hs_a, vs_a, ur_a;
    logic [3:0]  hc_a;
    logic [2:0]  nv_a;
    logic [11:0] rgb_o_a;
    logic [1:0]  fc_a;

    logic        nf_b, hb_b, hs_b, vs_b, ur_b;
    logic [9:0]  hc_b;
    logic [9:0]  nv_b;
    logic [11:0] rgb_o_b;
    logic [15:0] fc_b;

    int cyc, checks, errors;

    vga_scanout #(
        .WIDTH(8), .HEIGHT(4),
        .HSYNC_FPORCH(2), .HSYNC_PULSE(3), .HSYNC_BPORCH(3),
        .VSYNC_FPORCH(1), .VSYNC_PULSE(2), .VSYNC_BPORCH(1),
        .PIPELINE_STAGES(2), .COLOR_BITS(4), .FRAME_CNT_WID(2)
    ) dut_a (
        .CLK(clk), .RST_N(rst_n), .enable(enable),
        .underrun_clr(underrun_clr),
        .pixIf_NEXT_FRAME(nf_a), .pixIf_H_BLANKING(hb_a),
        .pixIf_H_CNT(hc_a), .pixIf_next_V_CNT(nv_a),
        .pixIf_rgb(rgb_a), .pixIf_valid(valid),
        .vgaIf_vga_h_sync(hs_a), .vgaIf_vga_v_sync(vs_a),
        .vgaIf_vga_rgb(rgb_o_a), .frame_cnt(fc_a), .underrun(ur_a)
    );

    vga_scanout #(
        .PIPELINE_STAGES(0)
    ) dut_b (
        .CLK(clk), .RST_N(rst_b_n), .enable(enable),
        .underrun_clr(underrun_clr),
        .pixIf_NEXT_FRAME(nf_b), .pixIf_H_BLANKING(hb_b),
        .pixIf_H_CNT(hc_b), .pixIf_next_V_CNT(nv_b),
        .pixIf_rgb(rgb_in_b), .pixIf_valid(valid),
        .vgaIf_vga_h_sync(hs_b), .vgaIf_vga_v_sync(vs_b),
        .vgaIf_vga_rgb(rgb_o_b), .frame_cnt(fc_b), .underrun(ur_b)
    );

    // Upstream model: returns rgb = requested column, two clocks later.
    always_ff @(posedge clk) begin
        p1 <= hc_a;
        p2 <= p1;
    end
    assign rgb_a    = {8'h00, p2};
    assign rgb_in_b = 12'h3A5;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        rst_n = 1'b0;
        rst_b_n = 1'b0;
        enable = 1'b1;
        underrun_clr = 1'b0;
        valid = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_hs", 32'(hs_a), 32'd1);
        chk("rst_vs", 32'(vs_a), 32'd1);
        chk("rst_rgb", 32'(rgb_o_a), 32'd0);
        chk("rst_fc", 32'(fc_a), 32'd0);
        chk("rst_ur", 32'(ur_a), 32'd0);
        chk("rst_hc", 32'(hc_a), 32'd0);
        chk("rst_nv", 32'(nv_a), 32'd1);

        rst_n = 1'b1;
        cyc = 0;

        to_cyc(3);   chk("f0_dark", 32'(rgb_o_a), 32'd0);
        to_cyc(5);   valid = 1'b0;
        to_cyc(6);   valid = 1'b1;
        chk("f0_ur_ign", 32'(ur_a), 32'd0);
        chk("f0_rgb_ign", 32'(rgb_o_a), 32'd0);
        to_cyc(7);   chk("hblank7", 32'(hb_a), 32'd0);
        to_cyc(8);   chk("hblank8", 32'(hb_a), 32'd1);
        to_cyc(12);  chk("hs12", 32'(hs_a), 32'd1);
        to_cyc(13);  chk("hs13", 32'(hs_a), 32'd0);
        to_cyc(15);  chk("hs15", 32'(hs_a), 32'd0);
        to_cyc(16);  chk("hs16", 32'(hs_a), 32'd1);
        to_cyc(55);  chk("nf55", 32'(nf_a), 32'd0);
        to_cyc(56);  chk("nf56", 32'(nf_a), 32'd1);
        to_cyc(57);  chk("nf57", 32'(nf_a), 32'd0);
        to_cyc(82);  chk("vs82", 32'(vs_a), 32'd1);
        to_cyc(83);  chk("vs83", 32'(vs_a), 32'd0);
        to_cyc(114); chk("vs114", 32'(vs_a), 32'd0);
        to_cyc(115); chk("vs115", 32'(vs_a), 32'd1);
        to_cyc(127); chk("fc127", 32'(fc_a), 32'd0);
        to_cyc(128); chk("fc128", 32'(fc_a), 32'd1);
        to_cyc(133); chk("rgb133", 32'(rgb_o_a), 32'd2);
        to_cyc(138); chk("rgb138", 32'(rgb_o_a), 32'd7);
        to_cyc(139); chk("rgb139", 32'(rgb_o_a), 32'd0);
        to_cyc(152); chk("rgb152", 32'(rgb_o_a), 32'd5);
        to_cyc(160); enable = 1'b0;
        to_cyc(184); chk("nf184", 32'(nf_a), 32'd1);
        to_cyc(185); chk("rgb185_lit", 32'(rgb_o_a), 32'd6);
        to_cyc(256); chk("fc256", 32'(fc_a), 32'd2);
        to_cyc(263); chk("f2_dark", 32'(rgb_o_a), 32'd0);
        to_cyc(300); enable = 1'b1;
        to_cyc(384); chk("fc384", 32'(fc_a), 32'd3);
        to_cyc(388); chk("rgb388", 32'(rgb_o_a), 32'd1);

        to_cyc(406); valid = 1'b0;
        chk("ur406", 32'(ur_a), 32'd0);
        to_cyc(407); valid = 1'b1;
        chk("ur_rgb407", 32'(rgb_o_a), 32'hFFF);
        chk("ur407", 32'(ur_a), 32'd1);
        to_cyc(408);
        chk("rgb408", 32'(rgb_o_a), 32'd5);
        chk("ur408", 32'(ur_a), 32'd1);
        to_cyc(410); chk("ur410", 32'(ur_a), 32'd1);
        to_cyc(411); underrun_clr = 1'b1;
        to_cyc(412); underrun_clr = 1'b0;
        chk("ur_clr412", 32'(ur_a), 32'd0);
        to_cyc(420); valid = 1'b0; underrun_clr = 1'b1;
        to_cyc(421); valid = 1'b1; underrun_clr = 1'b0;
        chk("ur_setwin", 32'(ur_a), 32'd1);
        chk("ur_rgb421", 32'(rgb_o_a), 32'hFFF);
        to_cyc(425); underrun_clr = 1'b1;
        to_cyc(426); underrun_clr = 1'b0;
        chk("ur_clr426", 32'(ur_a), 32'd0);

        to_cyc(511); chk("fc511", 32'(fc_a), 32'd3);
        to_cyc(512); chk("fc_wrap", 32'(fc_a), 32'd0);

        for (int c = 512; c < 640; c++) begin
            int pos;
            to_cyc(c);
            pos = c - 2;
            valid = ((pos % 16) < 8) && (((pos / 16) % 8) < 4);
            if (c == 524) chk("blank524", 32'(rgb_o_a), 32'd0);
            if (c == 537) chk("act537", 32'(rgb_o_a), 32'd6);
            if (c == 597) chk("vblank597", 32'(rgb_o_a), 32'd0);
        end
        chk("blank_ur", 32'(ur_a), 32'd0);
        to_cyc(640); valid = 1'b1;

        to_cyc(660); valid = 1'b0;
        to_cyc(661); valid = 1'b1;
        to_cyc(670); chk("ur670", 32'(ur_a), 32'd1);
        to_cyc(677);
        chk("pre_rgb", 32'(rgb_o_a), 32'd2);
        chk("pre_hc", 32'(hc_a), 32'd5);
        chk("pre_fc", 32'(fc_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_hs", 32'(hs_a), 32'd1);
        chk("ar_vs", 32'(vs_a), 32'd1);
        chk("ar_rgb", 32'(rgb_o_a), 32'd0);
        chk("ar_hc", 32'(hc_a), 32'd0);
        chk("ar_nv", 32'(nv_a), 32'd1);
        chk("ar_fc", 32'(fc_a), 32'd0);
        chk("ar_ur", 32'(ur_a), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        chk("rr_hc0", 32'(hc_a), 32'd0);
        to_cyc(5);  chk("rr_hc5", 32'(hc_a), 32'd5);
        to_cyc(6);  chk("rr_dark", 32'(rgb_o_a), 32'd0);
        to_cyc(13); chk("rr_hs13", 32'(hs_a), 32'd0);

        chk("b_rst_hs", 32'(hs_b), 32'd1);
        chk("b_rst_hc", 32'(hc_b), 32'd0);
        rst_b_n = 1'b1;
        cyc = 0;
        to_cyc(656);  chk("b_hs656", 32'(hs_b), 32'd1);
        to_cyc(657);  chk("b_hs657", 32'(hs_b), 32'd0);
        to_cyc(700);  chk("b_dark", 32'(rgb_o_b), 32'd0);
        to_cyc(752);  chk("b_hs752", 32'(hs_b), 32'd0);
        to_cyc(753);  chk("b_hs753", 32'(hs_b), 32'd1);
        to_cyc(799);
        chk("b_hc799", 32'(hc_b), 32'd799);
        chk("b_nv799", 32'(nv_b), 32'd1);
        to_cyc(800);
        chk("b_hc800", 32'(hc_b), 32'd0);
        chk("b_nv800", 32'(nv_b), 32'd2);
        to_cyc(1456); chk("b_hs1456", 32'(hs_b), 32'd1);
        to_cyc(1457);
        chk("b_hs1457", 32'(hs_b), 32'd0);
        chk("b_vs1457", 32'(vs_b), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Parametrised VGA scan-out engine and next-generation pixel-bus/VGA-bus bridge. It generates the raster counters, sync pulses and blanking, and requests pixels from the upstream pixel pipeline ahead of time. It then drives registered RGB aligned with sync. Compared with the earlier generation it adds:
- generic colour depth
- asynchronous reset
- frame-boundary display enable
- per-pixel valid handshake with underrun substitution and a sticky flag
- frame counter

## Interface
Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- HSYNC_FPORCH / HSYNC_PULSE / HSYNC_BPORCH, 16 / 96 / 48, horizontal porch and pulse lengths in clocks
- VSYNC_FPORCH / VSYNC_PULSE / VSYNC_BPORCH, 10 / 2 / 33, vertical porch and pulse lengths in lines
- HSYNC_POLARITY_NEG, 1, 1 = hsync active low
- VSYNC_POLARITY_NEG, 1, 1 = vsync active low
- PIPELINE_STAGES, 2, upstream pixel latency in clocks, legal range 0..15
- COLOR_BITS, 4, bits per colour channel
- UNDERRUN_RGB, {3*COLOR_BITS{1'b1}}, colour driven on underrun as {r,g,b}
- FRAME_CNT_WID, 16, frame counter width

Ports (HW = $clog2(H_SIZE), VW = $clog2(V_SIZE), where H_SIZE and V_SIZE are the sums of active, porch and pulse lengths):
- CLK  in  1  pixel clock; the only clock
- RST_N  in  1  reset; asynchronous, active-low
- enable  in  1  display enable, latched at frame start
- underrun_clr  in  1  clears underrun
- pixIf_NEXT_FRAME  out  1  one-cycle pulse at v_cnt==HEIGHT-1 && h_cnt==WIDTH
- pixIf_H_BLANKING  out  1  h_cnt >= WIDTH
- pixIf_H_CNT  out  HW  current column request
- pixIf_next_V_CNT  out  VW  v_cnt+1, wrapping to 0 after V_SIZE-1
- pixIf_rgb  in  3*COLOR_BITS  {r,g,b} for the request issued PIPELINE_STAGES cycles earlier
- pixIf_valid  in  1  pixIf_rgb is valid
- vgaIf_vga_h_sync  out  1  hsync
- vgaIf_vga_v_sync  out  1  vsync
- vgaIf_vga_rgb  out  3*COLOR_BITS  {r,g,b} to the DAC
- frame_cnt  out  FRAME_CNT_WID  completed frames, modulo 2^FRAME_CNT_WID
- underrun  out  1  sticky underrun flag

## Operation
- **Counters:**
  - h_cnt runs 0..H_SIZE-1 and wraps to 0.
  - v_cnt advances only on the h_cnt wrap, runs 0..V_SIZE-1 and wraps to 0.
  - Both are unsigned with widths HW and VW.
- **Sync generation:**
  - Raw hsync is active for h_cnt in [WIDTH+HSYNC_FPORCH, WIDTH+HSYNC_FPORCH+HSYNC_PULSE).
  - Raw vsync is active for v_cnt in [HEIGHT+VSYNC_FPORCH, HEIGHT+VSYNC_FPORCH+VSYNC_PULSE).
  - Both are inverted when the matching *_POLARITY_NEG is 1.
- **Active region:** h_cnt < WIDTH && v_cnt < HEIGHT. Its flag is delayed through PIPELINE_STAGES+1 registers.
- **Frame start** is the cycle in which the counters wrap from (H_SIZE-1, V_SIZE-1) to (0,0). On that edge:
  - enable_q <= enable
  - frame_cnt increments and wraps silently
- Changes to enable mid-frame have no effect until the next frame start.
- **Output colour**, evaluated at the stage where pixIf_rgb is sampled:
  - not active, or enable_q==0 → 0
  - active, enable_q==1, pixIf_valid==1 → pixIf_rgb
  - active, enable_q==1, pixIf_valid==0 → UNDERRUN_RGB, and underrun is set
- **Underrun flag:**
  - underrun_clr clears the flag.
  - If a set and underrun_clr occur in the same cycle, set wins.
  - pixIf_valid is ignored outside the active region and while enable_q==0.

## Timing
- **Latency:**
  - Position P is driven on pixIf_H_CNT / v_cnt in cycle t.
  - Upstream presents pixIf_rgb/pixIf_valid for P in cycle t+PIPELINE_STAGES.
  - vgaIf_vga_rgb, hsync and vsync for P appear together in cycle t+PIPELINE_STAGES+1.
  - Sync and colour are therefore always aligned.
- All outputs are registered, except the pixIf_* request signals, which decode the counter registers directly.
- **Reset values (asserted):**
  - h_cnt = v_cnt = 0
  - whole sync delay line at the inactive level (~polarity); vga_h_sync = HSYNC_POLARITY_NEG, vga_v_sync = VSYNC_POLARITY_NEG
  - active delay line = 0
  - vgaIf_vga_rgb = 0
  - enable_q = 0, frame_cnt = 0, underrun = 0
- **Reset release:** counting starts on the first CLK edge after RST_N rises. Because enable_q resets to 0, the first frame after reset is always dark.
- **Reset mid-frame:** all state returns to reset values immediately, with no clock needed; the raster restarts at (0,0).
- **pixIf_NEXT_FRAME:** exactly one cycle per frame. It precedes the first active pixel of the next frame by (V_SIZE-HEIGHT)*H_SIZE + (H_SIZE-WIDTH) cycles.

## Test plan
Small test geometry unless stated: WIDTH=8, HSYNC 2/3/3 (H_SIZE=16), HEIGHT=4, VSYNC 1/2/1 (V_SIZE=8), PIPELINE_STAGES=2, negative polarities.
1. **Reset and raster:** release RST_N with enable=1.
   - vga_h_sync is low in cycles 13..15 of every 16-cycle line.
   - vga_v_sync is low for lines 5..6, delayed by 3 cycles.
   - pixIf_NEXT_FRAME pulses at cycle 56 and every 128 cycles after.
   - frame_cnt reads 1 after cycle 128.
2. **Enable latching:**
   - Frame 0 RGB is all 0.
   - From frame 1, upstream returning rgb = h_cnt appears at vga output 3 cycles after the request.
   - Dropping enable mid-frame 1 still leaves the rest of frame 1 lit; frame 2 is black.
3. **Underrun:** in a lit frame, drop pixIf_valid for one active pixel.
   - That pixel outputs 12'hFFF.
   - underrun rises on the same output cycle and stays set until underrun_clr.
   - Set and clr in the same cycle leaves underrun=1.
4. **Valid ignored in blanking:** pixIf_valid=0 throughout the blanking intervals → underrun stays 0 and output is 0.
5. **Async reset mid-line:** assert RST_N low at h_cnt=5, v_cnt=2 between clock edges.
   - Sync outputs go high and rgb goes 0 without a clock edge.
   - After release, the raster restarts at (0,0).
6. **Default geometry:** default parameters and PIPELINE_STAGES=0.
   - Period is 800×525 cycles.
   - hsync is low for h_cnt 656..751, output 1 cycle later.
   - frame_cnt wraps from 65535 to 0; use a forced counter start for this check.
